// File: rtl/mem_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_arbiter_if
//  Purpose  : One burst read channel: a request (start address and
//             beats-minus-1 length) followed by a stream of read beats.
//  Modports : master - issues requests and accepts beats
//                      (drives req_addr/req_len/req_valid and rd_ready)
//             slave  - accepts requests and returns beats
//                      (drives req_ready and rdata/rd_valid/rd_last)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [4:0]            req_len;
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;

    modport master (
        output req_addr, req_len, req_valid, rd_ready,
        input  req_ready, rdata, rd_valid, rd_last
    );

    modport slave (
        input  req_addr, req_len, req_valid, rd_ready,
        output req_ready, rdata, rd_valid, rd_last
    );
endinterface
`default_nettype wire

// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_arbiter
//  Purpose  : Shares one memory burst read channel between the CPU data-side
//             read path (m0) and the DMA read channel (m1). The grant is held
//             from request acceptance until the last beat is handshaked, so
//             bursts never interleave; one burst is outstanding at a time.
//  Ports    : clk, rst (synchronous, active-low)
//             m0, m1  - requester channels (slave modport)
//             mem     - memory channel (master modport)
//             gnt_id  - granted port, meaningful while busy=1
//             busy    - 1 while a request or its data phase is in flight
//  Config   : MEM_ARB_RR_EN defined   -> round-robin between the two ports
//             MEM_ARB_RR_EN undefined -> fixed priority, m0 always wins
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_rd_arbiter_if.slave  m0,
    mem_rd_arbiter_if.slave  m1,
    mem_rd_arbiter_if.master mem,
    output logic             gnt_id,
    output logic             busy
);

    typedef enum logic [2:0] {
        c_ST_IDLE = 3'b001,
        c_ST_REQ  = 3'b010,
        c_ST_DATA = 3'b100
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_DATA_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO = '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_gnt_id;
    logic [4:0]            r_beat_left;
    logic                  w_win;
    logic                  w_any_req;
    logic                  w_gnt_req_valid;
    logic                  w_gnt_rd_ready;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [4:0]            w_gnt_len;
    logic                  w_req_hs;
    logic                  w_rd_hs;

    assign w_any_req       = m0.req_valid | m1.req_valid;
    assign w_gnt_req_valid = r_gnt_id ? m1.req_valid : m0.req_valid;
    assign w_gnt_rd_ready  = r_gnt_id ? m1.rd_ready  : m0.rd_ready;
    assign w_gnt_addr      = r_gnt_id ? m1.req_addr  : m0.req_addr;
    assign w_gnt_len       = r_gnt_id ? m1.req_len   : m0.req_len;

`ifdef MEM_ARB_RR_EN
    // Port granted by the most recently completed burst. Reset to port 1 so
    // that port 0 wins the first contested arbitration.
    logic r_last_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_rd_hs && mem.rd_last) begin
            r_last_gnt <= r_gnt_id;
        end
    end

    // Contested: the port not granted last wins; otherwise the lone requester.
    assign w_win = (m0.req_valid && m1.req_valid) ? ~r_last_gnt : m1.req_valid;
`else
    // Port 1 only wins when port 0 is not requesting.
    assign w_win = ~m0.req_valid;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_gnt_id    <= 1'b0;
            r_beat_left <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE && w_any_req) begin
                r_gnt_id <= w_win;
            end
            if (w_req_hs) begin
                r_beat_left <= w_gnt_len;
            end else if (w_rd_hs && r_beat_left != 5'd0) begin
                r_beat_left <= r_beat_left - 5'd1;
            end
        end
    end

    // Outputs are gated by state so everything is zero in IDLE, which also
    // gives the reset values once the state register has been cleared.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_hs      = 1'b0;
        w_rd_hs       = 1'b0;
        mem.req_addr  = c_ADDR_ZERO;
        mem.req_len   = 5'd0;
        mem.req_valid = 1'b0;
        mem.rd_ready  = 1'b0;
        m0.req_ready  = 1'b0;
        m0.rdata      = c_DATA_ZERO;
        m0.rd_valid   = 1'b0;
        m0.rd_last    = 1'b0;
        m1.req_ready  = 1'b0;
        m1.rdata      = c_DATA_ZERO;
        m1.rd_valid   = 1'b0;
        m1.rd_last    = 1'b0;

        unique case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                mem.req_addr  = w_gnt_addr;
                mem.req_len   = w_gnt_len;
                mem.req_valid = w_gnt_req_valid;
                if (r_gnt_id) begin
                    m1.req_ready = mem.req_ready;
                end else begin
                    m0.req_ready = mem.req_ready;
                end
                // A requester withdrawing before acceptance abandons the burst.
                if (!w_gnt_req_valid) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (mem.req_ready) begin
                    w_req_hs    = 1'b1;
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                mem.rd_ready = w_gnt_rd_ready;
                if (r_gnt_id) begin
                    m1.rdata    = mem.rdata;
                    m1.rd_valid = mem.rd_valid;
                    m1.rd_last  = mem.rd_last;
                end else begin
                    m0.rdata    = mem.rdata;
                    m0.rd_valid = mem.rd_valid;
                    m0.rd_last  = mem.rd_last;
                end
                w_rd_hs = mem.rd_valid & w_gnt_rd_ready;
                if (w_rd_hs && mem.rd_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign busy   = (r_state != c_ST_IDLE);
    assign gnt_id = r_gnt_id;

    // The remaining-beat counter must have run out exactly when memory flags
    // the last beat; anything else means memory and requester disagree on
    // the burst length.
    a_last_beat_count: assert property (@(posedge clk) disable iff (!rst)
        (w_rd_hs && mem.rd_last) |-> (r_beat_left == 5'd0));

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rd_arbiter
//  Purpose  : Self-checking bench for mem_rd_arbiter. A behavioural memory
//             returns len+1 beats per accepted request; expected grants and
//             per-port beats are queued when stimulus is issued and checked
//             as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic gnt_id;
    logic busy;

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0_if ();
    mem_rd_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1_if ();
    mem_rd_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_if ();

    mem_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .m0     (m0_if),
        .m1     (m1_if),
        .mem    (mem_if),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [32:0] q_beat0[$];     // {last, data}
    logic [32:0] q_beat1[$];
    logic [37:0] q_gnt[$];       // {port, addr, len}
    int          cnt0 = 0;
    int          cnt1 = 0;
    logic        cur_port = 1'b0;
    logic        tog0 = 1'b0;
    int          mstall = 0;
    logic        mbusy = 1'b0;
    logic [37:0] mon_g;
    logic [32:0] mon_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
        return (a + 32'(i) * 32'd4) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory model ----------------
    logic [31:0] m_addr;
    logic [4:0]  m_len;
    int          m_idx;
    initial begin
        logic rq, rh, rs;
        logic [31:0] a;
        logic [4:0]  l;
        mem_if.req_ready = 1'b0;
        mem_if.rd_valid  = 1'b0;
        mem_if.rd_last   = 1'b0;
        mem_if.rdata     = '0;
        m_addr = '0; m_len = '0; m_idx = 0;
        forever begin
            @(negedge clk);
            rq = mem_if.req_valid & mem_if.req_ready;
            rh = mem_if.rd_valid & mem_if.rd_ready;
            rs = rst;
            a  = mem_if.req_addr;
            l  = mem_if.req_len;
            @(posedge clk);
            #1;
            if (!rs) begin
                mbusy = 1'b0;
                m_idx = 0;
            end else if (rq) begin
                mbusy  = 1'b1;
                m_addr = a;
                m_len  = l;
                m_idx  = 0;
            end else if (rh) begin
                if (m_idx == int'(m_len)) mbusy = 1'b0;
                else m_idx++;
            end
            if (mstall > 0) mstall--;
            mem_if.req_ready = !mbusy && (mstall == 0);
            mem_if.rd_valid  = mbusy;
            mem_if.rdata     = mbusy ? beat_data(m_addr, m_idx) : 32'd0;
            mem_if.rd_last   = mbusy && (m_idx == int'(m_len));
        end
    end

    // ---------------- requester read-ready drivers ----------------
    initial begin
        m0_if.rd_ready = 1'b1;
        m1_if.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m0_if.rd_ready = tog0 ? ~m0_if.rd_ready : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (mem_if.req_valid && mem_if.req_ready) begin
                if (q_gnt.size() == 0) begin
                    check("unexpected_mem_req", 1, 0);
                end else begin
                    mon_g = q_gnt.pop_front();
                    check("gnt_id", gnt_id, mon_g[37]);
                    check("mem_req_addr", mem_if.req_addr, mon_g[36:5]);
                    check("mem_req_len", mem_if.req_len, mon_g[4:0]);
                    cur_port = mon_g[37];
                end
            end
            if (mem_if.rd_valid)
                check("rd_ready_mirror", mem_if.rd_ready,
                      cur_port ? m1_if.rd_ready : m0_if.rd_ready);
            if (m0_if.rd_valid) begin
                if (q_beat0.size() == 0) begin
                    check("m0_unexpected_beat", 1, 0);
                end else if (m0_if.rd_ready) begin
                    mon_b = q_beat0.pop_front();
                    check("m0_rdata", m0_if.rdata, mon_b[31:0]);
                    check("m0_rd_last", m0_if.rd_last, mon_b[32]);
                    cnt0++;
                end
            end
            if (m1_if.rd_valid) begin
                if (q_beat1.size() == 0) begin
                    check("m1_unexpected_beat", 1, 0);
                end else if (m1_if.rd_ready) begin
                    mon_b = q_beat1.pop_front();
                    check("m1_rdata", m1_if.rdata, mon_b[31:0]);
                    check("m1_rd_last", m1_if.rd_last, mon_b[32]);
                    cnt1++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input bit p, input logic [31:0] a, input logic [4:0] l);
        bit done = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            if (p) q_beat1.push_back({(i == int'(l)), beat_data(a, i)});
            else   q_beat0.push_back({(i == int'(l)), beat_data(a, i)});
        end
        if (p) begin
            m1_if.req_addr = a; m1_if.req_len = l; m1_if.req_valid = 1'b1;
        end else begin
            m0_if.req_addr = a; m0_if.req_len = l; m0_if.req_valid = 1'b1;
        end
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            done = p ? (m1_if.req_valid && m1_if.req_ready)
                     : (m0_if.req_valid && m0_if.req_ready);
            @(posedge clk);
            #1;
        end
        if (!done) check("req_timeout", 0, 1);
        if (p) m1_if.req_valid = 1'b0;
        else   m0_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk);
            #1;
            ok = (q_beat0.size() == 0) && (q_beat1.size() == 0) &&
                 (q_gnt.size() == 0) && !mbusy;
        end
        if (!ok) check("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},          busy, 0);
        check({tag, ".gnt_id"},        gnt_id, 0);
        check({tag, ".mem_req_valid"}, mem_if.req_valid, 0);
        check({tag, ".mem_rd_ready"},  mem_if.rd_ready, 0);
        check({tag, ".mem_req_addr"},  mem_if.req_addr, 0);
        check({tag, ".mem_req_len"},   mem_if.req_len, 0);
        check({tag, ".m0_req_ready"},  m0_if.req_ready, 0);
        check({tag, ".m0_rd_valid"},   m0_if.rd_valid, 0);
        check({tag, ".m0_rd_last"},    m0_if.rd_last, 0);
        check({tag, ".m0_rdata"},      m0_if.rdata, 0);
        check({tag, ".m1_req_ready"},  m1_if.req_ready, 0);
        check({tag, ".m1_rd_valid"},   m1_if.rd_valid, 0);
        check({tag, ".m1_rd_last"},    m1_if.rd_last, 0);
        check({tag, ".m1_rdata"},      m1_if.rdata, 0);
    endtask

    // ---------------- main sequence ----------------
    int order[6];
    int base;
    int k0;
    int k1;

    initial begin
        m0_if.req_valid = 1'b0; m0_if.req_addr = '0; m0_if.req_len = '0;
        m1_if.req_valid = 1'b0; m1_if.req_addr = '0; m1_if.req_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single port-0 burst of 8 beats
        q_gnt.push_back({1'b0, 32'h0000_1000, 5'd7});
        base = cnt0;
        do_req(1'b0, 32'h0000_1000, 5'd7);
        wait_idle();
        check("single_beats", cnt0 - base, 8);

        // Both ports contend, three bursts each
`ifdef MEM_ARB_RR_EN
        order = '{0, 1, 0, 1, 0, 1};
`else
        order = '{0, 0, 0, 1, 1, 1};
`endif
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (order[i] == 0) begin
                q_gnt.push_back({1'b0, 32'h0000_1100 + 32'(k0) * 32'd64, 5'(k0 + 1)});
                k0++;
            end else begin
                q_gnt.push_back({1'b1, 32'h0000_9000 + 32'(k1) * 32'd64, 5'd2});
                k1++;
            end
        end
        fork
            begin
                for (int k = 0; k < 3; k++)
                    do_req(1'b0, 32'h0000_1100 + 32'(k) * 32'd64, 5'(k + 1));
            end
            begin
                for (int k = 0; k < 3; k++)
                    do_req(1'b1, 32'h0000_9000 + 32'(k) * 32'd64, 5'd2);
            end
        join
        wait_idle();

        // Backpressure on the granted read-ready
        tog0 = 1'b1;
        q_gnt.push_back({1'b0, 32'h0000_2000, 5'd5});
        do_req(1'b0, 32'h0000_2000, 5'd5);
        wait_idle();
        tog0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Request stall while port 1 is also requesting
        mstall = 6;
        @(posedge clk);
        #1;
        q_gnt.push_back({1'b0, 32'h0000_3000, 5'd3});
        q_gnt.push_back({1'b1, 32'h0000_3100, 5'd1});
        fork
            do_req(1'b0, 32'h0000_3000, 5'd3);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_req(1'b1, 32'h0000_3100, 5'd1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                repeat (3) begin
                    @(negedge clk);
                    check("stall.gnt_id", gnt_id, 0);
                    check("stall.busy", busy, 1);
                    check("stall.m1_req_ready", m1_if.req_ready, 0);
                    check("stall.mem_req_valid", mem_if.req_valid, 1);
                end
            end
        join
        wait_idle();

        // Requester drops its valid while the request is pending
        mstall = 20;
        @(posedge clk);
        #1;
        m0_if.req_addr  = 32'h0000_4000;
        m0_if.req_len   = 5'd2;
        m0_if.req_valid = 1'b1;
        @(posedge clk);
        #1;
        m0_if.req_valid = 1'b0;
        @(negedge clk);
        check("drop.busy_in_req", busy, 1);
        check("drop.mem_req_valid", mem_if.req_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop.busy_after", busy, 0);
        check("drop.mem_req_valid_after", mem_if.req_valid, 0);
        mstall = 0;
        repeat (5) @(posedge clk);
        #1;
        check("drop.still_idle", busy, 0);

        // Reset during beat 3 of 8
        q_gnt.push_back({1'b0, 32'h0000_5000, 5'd7});
        base = cnt0;
        do_req(1'b0, 32'h0000_5000, 5'd7);
        for (int c = 0; c < 200 && (cnt0 - base) < 2; c++) begin
            @(posedge clk);
            #1;
        end
        check("reset.reached_beat3", cnt0 - base, 2);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_burst_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_beat0.delete();
        repeat (3) @(posedge clk);
        #1;

        // Arbiter usable again after the mid-burst reset
        q_gnt.push_back({1'b0, 32'h0000_6000, 5'd1});
        do_req(1'b0, 32'h0000_6000, 5'd1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
